// File: rtl/rr_arb_pkg.sv
// Shared types and the round-robin search helper for rr_decoder_arbiter.
package rr_arb_pkg;

    localparam int N    = 3;
    localparam int NREQ = 2**N;

    typedef enum logic {IDLE, BUSY} arb_state_t;

    typedef struct packed {
        logic         found;
        logic [N-1:0] idx;
    } pick_t;

    // First set bit of req scanning ptr, ptr+1, ... with wrap-around.
    function automatic pick_t rr_pick(input logic [NREQ-1:0] req, input logic [N-1:0] ptr);
        pick_t        res;
        logic [N-1:0] cand;
        res = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = ptr + i[N-1:0];
            if (!res.found && req[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/binary_decoder_3b8b.sv
// 3-to-8 binary decoder with enable; output is all zeros when en is low.
module binary_decoder_3b8b (
    input  logic [2:0] sel,
    input  logic       en,
    output logic [7:0] out
);

    always_comb begin
        out = 8'h00;
        if (en) out[sel] = 1'b1;
    end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter with binary winner index expanded to a one-hot grant.
// Optional hold-time limit enabled by defining ARB_TIMEOUT_EN.
module rr_decoder_arbiter #(
    parameter int N       = 3,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2**N-1:0] req,
    input  logic            done,
    output logic [2**N-1:0] grant,
    output logic [N-1:0]    grant_idx,
    output logic            busy,
    output logic            timeout
);
    import rr_arb_pkg::*;

    if (TIMEOUT < 2) begin : g_timeout_range
        $error("rr_decoder_arbiter: TIMEOUT must be >= 2");
    end

    arb_state_t   state;
    logic [N-1:0] ptr;
    logic [N-1:0] next_ptr;
    logic         real_rel;
    logic         rel;
    pick_t        pick_idle;
    pick_t        pick_rel;

    assign busy      = (state == BUSY);
    assign next_ptr  = grant_idx + 1'b1;
    assign real_rel  = done || !req[grant_idx];
    assign pick_idle = rr_pick(req, ptr);
    assign pick_rel  = rr_pick(req, next_ptr);

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] hold_cnt;
    logic          force_rel;

    assign force_rel = (hold_cnt == CW'(TIMEOUT - 1));
    assign rel       = real_rel || force_rel;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= busy && force_rel && !real_rel;
            if (!busy || rel) hold_cnt <= '0;
            else              hold_cnt <= hold_cnt + 1'b1;
        end
    end
`else
    assign rel     = real_rel;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            grant_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_idle.found) begin
                        grant_idx <= pick_idle.idx;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    // Released owner drops to lowest priority; hand over with no idle bubble.
                    if (rel) begin
                        ptr <= next_ptr;
                        if (pick_rel.found) grant_idx <= pick_rel.idx;
                        else                state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    binary_decoder_3b8b u_dec (
        .sel (grant_idx),
        .en  (busy),
        .out (grant)
    );

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed self-checking bench for rr_decoder_arbiter (table vectors plus corner sequences).
module tb_rr_decoder_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       busy;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] req;
        logic       done;
        logic       busy;
        logic [2:0] idx;
        logic [7:0] grant;
    } vec_t;

    vec_t vecs[19];

    rr_decoder_arbiter #(.N(3), .TIMEOUT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .done      (done),
        .grant     (grant),
        .grant_idx (grant_idx),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_outs(input string name, input logic b, input logic [2:0] idx,
                              input logic [7:0] g, input logic to);
        check({name, ".busy"}, {7'd0, busy}, {7'd0, b});
        if (b) check({name, ".idx"}, {5'd0, grant_idx}, {5'd0, idx});
        check({name, ".grant"}, grant, g);
        check({name, ".timeout"}, {7'd0, timeout}, {7'd0, to});
        check({name, ".onehot"}, 8'($countones(grant)), b ? 8'd1 : 8'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    function automatic vec_t mk(logic [7:0] r, logic d, logic b, logic [2:0] i, logic [7:0] g);
        vec_t v;
        v.req = r; v.done = d; v.busy = b; v.idx = i; v.grant = g;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(8'h00, 0, 0, 3'd0, 8'h00);
        vecs[1]  = mk(8'h00, 0, 0, 3'd0, 8'h00);
        vecs[2]  = mk(8'h00, 0, 0, 3'd0, 8'h00);
        vecs[3]  = mk(8'h00, 0, 0, 3'd0, 8'h00);
        vecs[4]  = mk(8'h00, 0, 0, 3'd0, 8'h00);
        vecs[5]  = mk(8'h24, 0, 1, 3'd2, 8'h04);
        vecs[6]  = mk(8'h24, 0, 1, 3'd2, 8'h04);
        vecs[7]  = mk(8'h24, 1, 1, 3'd5, 8'h20);
        vecs[8]  = mk(8'h24, 1, 1, 3'd2, 8'h04);
        vecs[9]  = mk(8'h20, 0, 1, 3'd5, 8'h20);
        vecs[10] = mk(8'h00, 0, 0, 3'd5, 8'h00);
        vecs[11] = mk(8'h00, 1, 0, 3'd5, 8'h00);
        vecs[12] = mk(8'h03, 0, 1, 3'd0, 8'h01);
        vecs[13] = mk(8'h03, 1, 1, 3'd1, 8'h02);
        vecs[14] = mk(8'h02, 1, 1, 3'd1, 8'h02);
        vecs[15] = mk(8'h82, 0, 1, 3'd1, 8'h02);
        vecs[16] = mk(8'h80, 0, 1, 3'd7, 8'h80);
        vecs[17] = mk(8'h81, 1, 1, 3'd0, 8'h01);
        vecs[18] = mk(8'h00, 0, 0, 3'd0, 8'h00);

        reset = 1'b1;
        req   = 8'h00;
        done  = 1'b0;
        step();
        step();
        check_outs("reset", 1'b0, 3'd0, 8'h00, 1'b0);
        check("reset.idx", {5'd0, grant_idx}, 8'h00);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            req  = vecs[i].req;
            done = vecs[i].done;
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].busy, vecs[i].idx, vecs[i].grant, 1'b0);
        end

        // Full request, done every third cycle: rotation 0..7 then 0.
        do_reset();
        req  = 8'hFF;
        done = 1'b0;
        step();
        for (int g = 0; g < 9; g++) begin
            check_outs($sformatf("rot%0d.a", g), 1'b1, 3'(g % 8), 8'h01 << (g % 8), 1'b0);
            step();
            check_outs($sformatf("rot%0d.b", g), 1'b1, 3'(g % 8), 8'h01 << (g % 8), 1'b0);
            step();
            check_outs($sformatf("rot%0d.c", g), 1'b1, 3'(g % 8), 8'h01 << (g % 8), 1'b0);
            done = 1'b1;
            step();
            done = 1'b0;
        end

        // Owner drops its request without done.
        do_reset();
        req = 8'h08;
        step();
        check_outs("drop.grant3", 1'b1, 3'd3, 8'h08, 1'b0);
        step();
        check_outs("drop.hold3", 1'b1, 3'd3, 8'h08, 1'b0);
        req = 8'h40;
        step();
        check_outs("drop.to6", 1'b1, 3'd6, 8'h40, 1'b0);
        req = 8'h00;
        step();
        check_outs("drop.idle", 1'b0, 3'd6, 8'h00, 1'b0);

        // Reset while busy, then regrant; second reset proves ptr returns to 0.
        do_reset();
        req = 8'h10;
        step();
        check_outs("rst.busy4", 1'b1, 3'd4, 8'h10, 1'b0);
        reset = 1'b1;
        step();
        check_outs("rst.cleared", 1'b0, 3'd0, 8'h00, 1'b0);
        check("rst.cleared.idx", {5'd0, grant_idx}, 8'h00);
        reset = 1'b0;
        step();
        check_outs("rst.regrant", 1'b1, 3'd4, 8'h10, 1'b0);
        done = 1'b1;
        step();
        done = 1'b0;
        check_outs("rst.rewin4", 1'b1, 3'd4, 8'h10, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        req   = 8'h11;
        step();
        check_outs("rst.ptr0", 1'b1, 3'd0, 8'h01, 1'b0);

`ifdef ARB_TIMEOUT_EN
        // Forced release after 16 busy cycles.
        req = 8'h00;
        do_reset();
        req = 8'h03;
        step();
        check_outs("to.c1", 1'b1, 3'd0, 8'h01, 1'b0);
        for (int c = 2; c <= 16; c++) begin
            step();
            check_outs($sformatf("to.c%0d", c), 1'b1, 3'd0, 8'h01, 1'b0);
        end
        step();
        check_outs("to.force", 1'b1, 3'd1, 8'h02, 1'b1);
        step();
        check_outs("to.after", 1'b1, 3'd1, 8'h02, 1'b0);

        // Real done in the final allowed cycle wins over the forced release.
        req = 8'h00;
        do_reset();
        req = 8'h03;
        step();
        for (int c = 2; c <= 16; c++) step();
        check_outs("tod.c16", 1'b1, 3'd0, 8'h01, 1'b0);
        done = 1'b1;
        step();
        done = 1'b0;
        check_outs("tod.done", 1'b1, 3'd1, 8'h02, 1'b0);
        step();
        check_outs("tod.after", 1'b1, 3'd1, 8'h02, 1'b0);
`else
        // Without the feature a long hold never releases and timeout stays low.
        req = 8'h00;
        do_reset();
        req = 8'h03;
        for (int c = 1; c <= 20; c++) step();
        check_outs("nto.hold", 1'b1, 3'd0, 8'h01, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
